operand_fetch_ctrl: RTL and testbench

// - Sequences the loads of operand registers A and B for the ALU from one shared sync-read register-file port.
// - Accepts a decoded instruction (rs1, rs2 or immediate), reads rs1, then rs2 or the immediate.
// - Drives the operand-register write enables and data, then presents the operand pair to execute with valid/ready.
// - Sits between decode and the operand registers / ALU.

---
 rtl/operand_fetch_ctrl_pkg.sv | 12 +
 rtl/operand_fetch_ctrl.sv | 96 +++++++++
 tb/tb_operand_fetch_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_ctrl_pkg.sv
// operand_fetch_ctrl_pkg: shared state encoding and width defaults for the operand fetch controller
package operand_fetch_ctrl_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_A  = 3'd1,
        S_RD_B  = 3'd2,
        S_CAP_B = 3'd3,
        S_ISSUE = 3'd4
    } state_e;
endpackage

// File: rtl/operand_fetch_ctrl.sv
// operand_fetch_ctrl: sequences operand A/B loads from one sync-read register-file port and issues the pair
// Ports: dec_* decode handshake and fields; rf_* shared register-file read port;
//        opa_*/opb_* operand register loads; op_valid/op_ready execute handshake; issue_cnt issued pairs.
module operand_fetch_ctrl
    import operand_fetch_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [ADDR_W-1:0] dec_rs1,
    input  logic [ADDR_W-1:0] dec_rs2,
    input  logic              dec_use_imm,
    input  logic [DATA_W-1:0] dec_imm,
    output logic              rf_ren,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              opa_we,
    output logic [DATA_W-1:0] opa_din,
    output logic              opb_we,
    output logic [DATA_W-1:0] opb_din,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [15:0]       issue_cnt
);
    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   rs1_q, rs1_d, rs2_q, rs2_d;
    logic                use_imm_q, use_imm_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic [15:0]         issue_cnt_q, issue_cnt_d;
    logic                in_rd_a, in_rd_b, in_cap_b, rd_b_imm, rd_b_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rs1_q       <= '0;
            rs2_q       <= '0;
            use_imm_q   <= 1'b0;
            imm_q       <= '0;
            issue_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            use_imm_q   <= use_imm_d;
            imm_q       <= imm_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        use_imm_d   = use_imm_q;
        imm_d       = imm_q;
        issue_cnt_d = issue_cnt_q;
        case (state_q)
            S_IDLE: if (dec_valid) begin
                state_d   = S_RD_A;
                rs1_d     = dec_rs1;
                rs2_d     = dec_rs2;
                use_imm_d = dec_use_imm;
                imm_d     = dec_imm;
            end
            S_RD_A:  state_d = S_RD_B;
            S_RD_B:  state_d = use_imm_q ? S_ISSUE : S_CAP_B;
            S_CAP_B: state_d = S_ISSUE;
            S_ISSUE: if (op_ready) begin
                state_d     = S_IDLE;
                issue_cnt_d = issue_cnt_q + 16'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_rd_a  = state_q == S_RD_A;
    assign in_rd_b  = state_q == S_RD_B;
    assign in_cap_b = state_q == S_CAP_B;
    assign rd_b_imm = in_rd_b && use_imm_q;
    assign rd_b_reg = in_rd_b && !use_imm_q;

    // async reset forces IDLE, so only dec_ready needs explicit gating to stay 0 while rst is held
    assign dec_ready = state_q == S_IDLE && !rst;
    assign rf_ren    = in_rd_a || rd_b_reg;
    assign rf_raddr  = in_rd_a ? rs1_q : rd_b_reg ? rs2_q : '0;
    assign opa_we    = in_rd_b;
    assign opa_din   = in_rd_b ? rf_rdata : '0;
    assign opb_we    = rd_b_imm || in_cap_b;
    assign opb_din   = rd_b_imm ? imm_q : in_cap_b ? rf_rdata : '0;
    assign op_valid  = state_q == S_ISSUE;
    assign issue_cnt = issue_cnt_q;
endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// tb_operand_fetch_ctrl: randomized self-checking bench with a transaction-level reference model
module tb_operand_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid, dec_ready, dec_use_imm;
    logic [2:0]  dec_rs1, dec_rs2, rf_raddr;
    logic [15:0] dec_imm, rf_rdata, opa_din, opb_din, issue_cnt;
    logic        rf_ren, opa_we, opb_we, op_valid, op_ready;

    logic [15:0] rf [8];
    logic [15:0] exp_cnt;
    int          n_cmp, n_bad;

    always #5 clk = ~clk;

    // register file with one-cycle read latency; garbage when not enabled
    always @(posedge clk) rf_rdata <= rf_ren ? rf[rf_raddr] : 16'($urandom);

    operand_fetch_ctrl dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_imm(dec_use_imm), .dec_imm(dec_imm),
        .rf_ren(rf_ren), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .opa_we(opa_we), .opa_din(opa_din),
        .opb_we(opb_we), .opb_din(opb_din),
        .op_valid(op_valid), .op_ready(op_ready),
        .issue_cnt(issue_cnt)
    );

    // one transaction; called right after a negedge with the controller idle
    task automatic run_op(input logic [2:0] rs1, input logic [2:0] rs2, input logic ui,
                          input logic [15:0] imm, input int delay, input string tag);
        logic [15:0] exp_a, exp_b, got_a, got_b;
        logic [2:0]  addrs [$];
        int lat, cyc, nwa, nwb, ca, cb, vcyc, nval, bad, held;
        exp_a = rf[rs1];
        exp_b = ui ? imm : rf[rs2];
        lat = ui ? 3 : 4;
        nwa = 0; nwb = 0; ca = -1; cb = -1; vcyc = -1; nval = 0; bad = 0; held = 0;
        got_a = 'x; got_b = 'x;
        n_cmp++;
        if (dec_ready !== 1'b1) begin n_bad++; $display("FAIL %s idle_ready got %b want 1", tag, dec_ready); end
        dec_valid = 1'b1; dec_rs1 = rs1; dec_rs2 = rs2; dec_use_imm = ui; dec_imm = imm;
        op_ready = 1'b0;
        @(negedge clk);
        cyc = 1;
        while (cyc <= 40) begin
            dec_valid = 1'b0; dec_rs1 = ~rs1; dec_rs2 = ~rs2; dec_use_imm = ~ui; dec_imm = 16'($urandom);
            if (vcyc >= 0 && !op_valid) break;
            if (dec_ready) bad++;
            if (rf_ren) addrs.push_back(rf_raddr);
            if (opa_we) begin nwa++; got_a = opa_din; ca = cyc; end
            if (opb_we) begin nwb++; got_b = opb_din; cb = cyc; end
            if (op_valid) begin
                if (vcyc < 0) vcyc = cyc;
                nval++;
                if (rf_ren || opa_we || opb_we) bad++;
                op_ready = held == delay;
                held++;
            end else op_ready = 1'($urandom);
            @(negedge clk);
            cyc++;
        end
        op_ready = 1'b0;
        n_cmp++;
        if (cyc > 40) begin n_bad++; $display("FAIL %s timeout after %0d cycles", tag, cyc); end
        if (nval > 0) exp_cnt = exp_cnt + 16'd1;
        n_cmp++; if (vcyc !== lat) begin n_bad++; $display("FAIL %s valid_cycle got %0d want %0d", tag, vcyc, lat); end
        n_cmp++; if (nval !== delay + 1) begin n_bad++; $display("FAIL %s valid_len got %0d want %0d", tag, nval, delay + 1); end
        n_cmp++; if (got_a !== exp_a || nwa != 1 || ca != 2) begin n_bad++; $display("FAIL %s opa got %h x%0d @%0d want %h x1 @2", tag, got_a, nwa, ca, exp_a); end
        n_cmp++; if (got_b !== exp_b || nwb != 1 || cb != lat - 1) begin n_bad++; $display("FAIL %s opb got %h x%0d @%0d want %h x1 @%0d", tag, got_b, nwb, cb, exp_b, lat - 1); end
        n_cmp++;
        if (addrs.size() != (ui ? 1 : 2) || addrs[0] !== rs1 || (!ui && addrs[1] !== rs2)) begin
            n_bad++; $display("FAIL %s rf_reads got %0d reads first %0d want %0d reads %0d/%0d", tag, addrs.size(), addrs.size() > 0 ? addrs[0] : 3'd0, ui ? 1 : 2, rs1, rs2);
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL %s busy_outputs got %0d violations want 0", tag, bad); end
        n_cmp++; if (issue_cnt !== exp_cnt) begin n_bad++; $display("FAIL %s issue_cnt got %h want %h", tag, issue_cnt, exp_cnt); end
        n_cmp++; if (dec_ready !== 1'b1) begin n_bad++; $display("FAIL %s back_to_idle got %b want 1", tag, dec_ready); end
    endtask

    task automatic test_reset;
        rst = 1'b1; dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0; dec_use_imm = 1'b0; dec_imm = '0; op_ready = 1'b0;
        #2;
        n_cmp++;
        if ({dec_ready, rf_ren, opa_we, opb_we, op_valid, issue_cnt} !== 21'd0) begin
            n_bad++; $display("FAIL reset_outputs got rdy=%b ren=%b cnt=%h want 0", dec_ready, rf_ren, issue_cnt);
        end
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        exp_cnt = '0;
        n_cmp++; if (dec_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release dec_ready got %b want 1", dec_ready); end
    endtask

    task automatic test_reset_mid;
        int stray;
        stray = 0;
        dec_valid = 1'b1; dec_rs1 = 3'd3; dec_rs2 = 3'd4; dec_use_imm = 1'b0; dec_imm = '0;
        @(negedge clk); dec_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({dec_ready, rf_ren, rf_raddr, opa_we, opa_din, opb_we, opb_din, op_valid, issue_cnt} !== 56'd0) begin
            n_bad++; $display("FAIL mid_reset_outputs got rdy=%b ren=%b ra=%0d awe=%b a=%h bwe=%b b=%h v=%b cnt=%h want all 0",
                              dec_ready, rf_ren, rf_raddr, opa_we, opa_din, opb_we, opb_din, op_valid, issue_cnt);
        end
        @(negedge clk); rst = 1'b0;
        exp_cnt = '0;
        repeat (3) begin
            @(negedge clk);
            if (opa_we || opb_we || op_valid || rf_ren) stray++;
        end
        n_cmp++; if (stray != 0 || dec_ready !== 1'b1) begin n_bad++; $display("FAIL mid_reset_after got stray=%0d rdy=%b want 0/1", stray, dec_ready); end
        n_cmp++; if (issue_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_reset_cnt got %h want 0000", issue_cnt); end
    endtask

    task automatic test_register_pair;
        rf[2] = 16'h1234; rf[5] = 16'hABCD;
        run_op(3'd2, 3'd5, 1'b0, 16'h0000, 0, "reg_pair");
    endtask

    task automatic test_immediate;
        rf[1] = 16'h0010;
        run_op(3'd1, 3'd6, 1'b1, 16'hFFFE, 0, "imm");
    endtask

    task automatic test_backpressure;
        run_op(3'd7, 3'd0, 1'b0, 16'h0000, 6, "backpressure_reg");
        run_op(3'd4, 3'd4, 1'b1, 16'h5A5A, 6, "backpressure_imm");
    endtask

    task automatic test_same_reg;
        rf[6] = 16'h0F0F;
        run_op(3'd6, 3'd6, 1'b0, 16'h0000, 1, "rs1_eq_rs2");
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 30; i++) begin
            rf[$urandom_range(0, 7)] = 16'($urandom);
            run_op(3'($urandom), 3'($urandom), 1'($urandom), 16'($urandom), int'($urandom_range(0, 3)), "random");
        end
    endtask

    task automatic test_wrap;
        force dut.issue_cnt_q = 16'hFFFF;
        #1 release dut.issue_cnt_q;
        exp_cnt = 16'hFFFF;
        run_op(3'd1, 3'd0, 1'b1, 16'h0001, 0, "wrap");
        run_op(3'd2, 3'd3, 1'b0, 16'h0000, 0, "after_wrap");
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; exp_cnt = '0;
        for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
        test_reset;
        test_register_pair;
        test_immediate;
        test_backpressure;
        test_same_reg;
        test_back_to_back;
        test_reset_mid;
        test_register_pair;
        test_wrap;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
